bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter D_SIZE, default 64, data word width.
REQ-002 The block SHALL have parameter Q_DEPTH, default 8, address width (2^Q_DEPTH words).
REQ-003 The block SHALL have port clk, input, 1, single clock, all state updates on posedge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port rN_req, input, 1, requester N (N=0,1) access request, held until granted.
REQ-006 The block SHALL have port rN_we, input, 1, requester N write (1) / read (0) select.
REQ-007 The block SHALL have port rN_addr, input, Q_DEPTH, requester N word address.
REQ-008 The block SHALL have port rN_din, input, D_SIZE, requester N write data.
REQ-009 The block SHALL have port rN_gnt, output, 1, request accepted this cycle.
REQ-010 The block SHALL have port rN_rvalid, output, 1, read data valid for requester N.
REQ-011 The block SHALL have port rN_rdata, output, D_SIZE, read data for requester N.
REQ-012 The block SHALL have port busy, output, 1, clear sweep in progress.
REQ-013 The block SHALL have ports bram_wr_en (out, 1), bram_wr_addr (out, Q_DEPTH), bram_wr_din (out, D_SIZE), bram_rd_addr (out, Q_DEPTH), bram_rd_dout (in, D_SIZE), driving a posedge dual-port RAM with registered addresses and 1-cycle read latency.

Function
- REQ-014 FSM states SHALL be CLEAR and RUN; reset enters CLEAR with counter 0.
- REQ-015 In CLEAR: bram_wr_en=1, bram_wr_addr=counter, bram_wr_din=0, counter increments each cycle, all gnt=0, busy=1.
- REQ-016 CLEAR SHALL go to RUN in the cycle after counter 2^Q_DEPTH-1 is written; busy=0 in RUN.
- REQ-017 In RUN, write and read ports SHALL be arbitrated independently; a write from one requester and a read from the other SHALL both be granted in the same cycle.
- REQ-018 Per port, a single contender SHALL be granted combinationally in its request cycle.
- REQ-019 Per port, two contenders SHALL be resolved round-robin: the requester not granted last on that port wins; after reset both pointers favour requester 0.
- REQ-020 Round-robin pointer SHALL update only on a grant for that port.
- REQ-021 Granted write: bram_wr_en=1, bram_wr_addr/bram_wr_din from the winner in the same cycle; otherwise bram_wr_en=0.
- REQ-022 Granted read: bram_rd_addr=winner addr same cycle; winner's rvalid SHALL be 1 exactly one cycle later with rdata=bram_rd_dout.
- REQ-023 rN_rdata SHALL be 0 when rN_rvalid=0.
- REQ-024 Same-cycle write and read to one address SHALL return the newly written data (write-first).
- REQ-025 Back-to-back reads by one requester SHALL sustain one grant per cycle when uncontended.
- REQ-026 rst asserted mid-operation SHALL drop all gnt/rvalid next cycle, discard in-flight reads, and restart CLEAR.

Reset
- REQ-027 After reset: gnt=0, rvalid=0, rdata=0, bram_wr_en=1 (clear), busy=1, counter=0, both RR pointers=0.

Structure
- REQ-028 A shared package SHALL hold the FSM state enum (CLEAR, RUN) and the requester-count constant (2).
- REQ-029 A sub-module rr_arb2 (2-way round-robin: req[1:0] in, gnt[1:0] out, pointer register, update-on-grant) SHALL be instantiated once per port.

Verification
- REQ-030 Reset, Q_DEPTH=8 -> busy high 256 cycles, wr_addr 0..255 with din 0, then busy=0, no gnt during sweep.
- REQ-031 r0 write addr 5 din 0xA5 while r1 reads addr 5 same cycle -> both gnt, r1_rvalid next cycle with rdata 0xA5.
- REQ-032 Both read continuously (addrs 1, 2) -> gnt alternates r0,r1,r0,... each rvalid 1 cycle after its grant, correct data.
- REQ-033 Both write same cycle -> r0 granted first, r1 granted next cycle; final RAM content of shared addr = r1 data.
- REQ-034 rst asserted the cycle after a read grant -> no rvalid issued, busy=1 next cycle.
- REQ-035 r1 reads addr 7 never written after clear -> rdata 0.

Source files
------------

// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and constants for the two-requester BRAM port arbiter.
package bram_port_arbiter_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int N_REQ = 2;

endpackage

// File: rtl/bram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie
// and moves to the other requester whenever a grant is issued.
module rr_arb2
    import bram_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one dual-port BRAM between two requesters: clears the RAM after reset,
// then arbitrates the write and read ports independently.
//   state | meaning
//   CLEAR | sweep every address with zero, no grants, busy=1
//   RUN   | per-port round-robin arbitration, busy=0
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int D_SIZE  = 64,
    parameter int Q_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               r0_req,
    input  logic               r0_we,
    input  logic [Q_DEPTH-1:0] r0_addr,
    input  logic [D_SIZE-1:0]  r0_din,
    output logic               r0_gnt,
    output logic               r0_rvalid,
    output logic [D_SIZE-1:0]  r0_rdata,
    input  logic               r1_req,
    input  logic               r1_we,
    input  logic [Q_DEPTH-1:0] r1_addr,
    input  logic [D_SIZE-1:0]  r1_din,
    output logic               r1_gnt,
    output logic               r1_rvalid,
    output logic [D_SIZE-1:0]  r1_rdata,
    output logic               busy,
    output logic               bram_wr_en,
    output logic [Q_DEPTH-1:0] bram_wr_addr,
    output logic [D_SIZE-1:0]  bram_wr_din,
    output logic [Q_DEPTH-1:0] bram_rd_addr,
    input  logic [D_SIZE-1:0]  bram_rd_dout
);

    state_t             state, state_nxt;
    logic [Q_DEPTH-1:0] cnt, cnt_nxt;
    logic               run;
    logic [N_REQ-1:0]   req, we, wr_req, rd_req, wr_gnt, rd_gnt, rvalid_q;

    assign req = {r1_req, r0_req};
    assign we  = {r1_we, r0_we};

    // Gating with rst keeps grants and read data quiet during the reset cycle itself.
    assign run    = (state == RUN) && !rst;
    assign wr_req = run ? (req & we) : '0;
    assign rd_req = run ? (req & ~we) : '0;

    rr_arb2 u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .gnt (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .gnt (rd_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            rvalid_q <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rvalid_q <= rd_gnt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        busy         = 1'b0;
        bram_wr_en   = 1'b0;
        bram_wr_addr = '0;
        bram_wr_din  = '0;
        bram_rd_addr = '0;
        case (state)
            CLEAR: begin
                busy         = 1'b1;
                bram_wr_en   = 1'b1;
                bram_wr_addr = cnt;
                cnt_nxt      = cnt + 1'b1;
                if (cnt == '1) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (|wr_gnt) begin
                    bram_wr_en   = 1'b1;
                    bram_wr_addr = wr_gnt[1] ? r1_addr : r0_addr;
                    bram_wr_din  = wr_gnt[1] ? r1_din : r0_din;
                end
                if (|rd_gnt) begin
                    bram_rd_addr = rd_gnt[1] ? r1_addr : r0_addr;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign r0_gnt    = wr_gnt[0] | rd_gnt[0];
    assign r1_gnt    = wr_gnt[1] | rd_gnt[1];
    assign r0_rvalid = rvalid_q[0] & ~rst;
    assign r1_rvalid = rvalid_q[1] & ~rst;
    assign r0_rdata  = r0_rvalid ? bram_rd_dout : '0;
    assign r1_rdata  = r1_rvalid ? bram_rd_dout : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural dual-port RAM
// (registered addresses, one-cycle read latency).
module tb_bram_port_arbiter;

    localparam int D = 64;
    localparam int Q = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         r0_req, r0_we, r1_req, r1_we;
    logic [Q-1:0] r0_addr, r1_addr;
    logic [D-1:0] r0_din, r1_din;
    logic         r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [D-1:0] r0_rdata, r1_rdata;
    logic         busy, bram_wr_en;
    logic [Q-1:0] bram_wr_addr, bram_rd_addr;
    logic [D-1:0] bram_wr_din, bram_rd_dout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.D_SIZE(D), .Q_DEPTH(Q)) dut (
        .clk          (clk),
        .rst          (rst),
        .r0_req       (r0_req),
        .r0_we        (r0_we),
        .r0_addr      (r0_addr),
        .r0_din       (r0_din),
        .r0_gnt       (r0_gnt),
        .r0_rvalid    (r0_rvalid),
        .r0_rdata     (r0_rdata),
        .r1_req       (r1_req),
        .r1_we        (r1_we),
        .r1_addr      (r1_addr),
        .r1_din       (r1_din),
        .r1_gnt       (r1_gnt),
        .r1_rvalid    (r1_rvalid),
        .r1_rdata     (r1_rdata),
        .busy         (busy),
        .bram_wr_en   (bram_wr_en),
        .bram_wr_addr (bram_wr_addr),
        .bram_wr_din  (bram_wr_din),
        .bram_rd_addr (bram_rd_addr),
        .bram_rd_dout (bram_rd_dout)
    );

    logic [D-1:0] mem [0:(1<<Q)-1];
    logic [Q-1:0] rd_q;

    always @(posedge clk) begin
        if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_din;
        rd_q <= bram_rd_addr;
    end
    assign bram_rd_dout = mem[rd_q];

    task automatic idle();
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_din = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_din = '0;
    endtask

    task automatic test_reset();
        logic [Q-1:0] ea;
        idle();
        rst = 1'b1;
        r0_req = 1'b1; r1_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid} !== 4'b0000 || r0_rdata !== '0 || r1_rdata !== '0) begin
            fails++;
            $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b rdata0=%h rdata1=%h, need all 0", r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata);
        end
        tests++;
        if (busy !== 1'b1 || bram_wr_en !== 1'b1 || bram_wr_addr !== '0) begin
            fails++;
            $display("FAIL reset_clear: busy=%b wr_en=%b wr_addr=%0d, need 1 1 0", busy, bram_wr_en, bram_wr_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < (1 << Q); i++) begin
            ea = i[Q-1:0];
            tests++;
            if (busy !== 1'b1 || bram_wr_en !== 1'b1 || bram_wr_addr !== ea || bram_wr_din !== '0 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin
                fails++;
                $display("FAIL sweep_%0d: busy=%b wr_en=%b addr=%0d din=%h gnt=%b%b, need 1 1 %0d 0 00", i, busy, bram_wr_en, bram_wr_addr, bram_wr_din, r0_gnt, r1_gnt, ea);
            end
            @(negedge clk);
        end
        idle();
        #1;
        tests++;
        if (busy !== 1'b0 || bram_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL sweep_end: busy=%b wr_en=%b, need 0 0", busy, bram_wr_en);
        end
    endtask

    task automatic test_write_contention();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'd9; r0_din = 64'h11;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'd9; r1_din = 64'h22;
        #1;
        tests++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0 || bram_wr_en !== 1'b1 || bram_wr_addr !== 8'd9 || bram_wr_din !== 64'h11) begin
            fails++;
            $display("FAIL wr_tie_first: gnt=%b%b wr_en=%b addr=%0d din=%h, need r0 only, 9, 11", r0_gnt, r1_gnt, bram_wr_en, bram_wr_addr, bram_wr_din);
        end
        @(negedge clk);
        r0_req = 1'b0;
        #1;
        tests++;
        if (r0_gnt !== 1'b0 || r1_gnt !== 1'b1 || bram_wr_din !== 64'h22) begin
            fails++;
            $display("FAIL wr_tie_second: gnt=%b%b din=%h, need r1 only, 22", r0_gnt, r1_gnt, bram_wr_din);
        end
        @(negedge clk);
        idle();
        r0_req = 1'b1; r0_addr = 8'd9;
        #1;
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 64'h22) begin
            fails++;
            $display("FAIL wr_tie_final: rvalid=%b rdata=%h, need 1 22", r0_rvalid, r0_rdata);
        end
    endtask

    task automatic test_same_cycle();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'd5; r0_din = 64'hA5;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'd5;
        #1;
        tests++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b1 || bram_wr_en !== 1'b1 || bram_rd_addr !== 8'd5) begin
            fails++;
            $display("FAIL rw_same_gnt: gnt=%b%b wr_en=%b rd_addr=%0d, need 11 1 5", r0_gnt, r1_gnt, bram_wr_en, bram_rd_addr);
        end
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (r1_rvalid !== 1'b1 || r1_rdata !== 64'hA5 || r0_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL rw_same_data: r1_rvalid=%b r1_rdata=%h r0_rvalid=%b, need 1 a5 0", r1_rvalid, r1_rdata, r0_rvalid);
        end
        @(negedge clk);
        #1;
        tests++;
        if (r1_rvalid !== 1'b0 || r1_rdata !== '0) begin
            fails++;
            $display("FAIL rdata_idle_zero: rvalid=%b rdata=%h, need 0 0", r1_rvalid, r1_rdata);
        end
    endtask

    task automatic test_alternating();
        int prev;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'd1; r0_din = 64'h1111;
        @(negedge clk);
        r0_addr = 8'd2; r0_din = 64'h2222;
        @(negedge clk);
        idle();
        r0_req = 1'b1; r0_addr = 8'd1;
        r1_req = 1'b1; r1_addr = 8'd2;
        for (int k = 0; k < 6; k++) begin
            #1;
            tests++;
            if (r0_gnt !== (k % 2 == 0) || r1_gnt !== (k % 2 == 1)) begin
                fails++;
                $display("FAIL rr_gnt_%0d: gnt=%b%b, need r%0d", k, r0_gnt, r1_gnt, k % 2);
            end
            if (k > 0) begin
                prev = (k - 1) % 2;
                tests++;
                if (prev == 0 ? (r0_rvalid !== 1'b1 || r0_rdata !== 64'h1111 || r1_rvalid !== 1'b0)
                              : (r1_rvalid !== 1'b1 || r1_rdata !== 64'h2222 || r0_rvalid !== 1'b0)) begin
                    fails++;
                    $display("FAIL rr_data_%0d: rvalid=%b%b rdata0=%h rdata1=%h, need r%0d data", k, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, prev);
                end
            end
            @(negedge clk);
        end
        idle();
        #1;
        tests++;
        if (r1_rvalid !== 1'b1 || r1_rdata !== 64'h2222) begin
            fails++;
            $display("FAIL rr_last: r1_rvalid=%b r1_rdata=%h, need 1 2222", r1_rvalid, r1_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [Q-1:0] a [3];
        logic [D-1:0] d [3];
        a[0] = 8'd1; a[1] = 8'd2; a[2] = 8'd5;
        d[0] = 64'h1111; d[1] = 64'h2222; d[2] = 64'hA5;
        for (int k = 0; k < 3; k++) begin
            r0_req = 1'b1; r0_we = 1'b0; r0_addr = a[k];
            #1;
            tests++;
            if (r0_gnt !== 1'b1 || (k > 0 && (r0_rvalid !== 1'b1 || r0_rdata !== d[k-1]))) begin
                fails++;
                $display("FAIL b2b_%0d: gnt=%b rvalid=%b rdata=%h", k, r0_gnt, r0_rvalid, r0_rdata);
            end
            @(negedge clk);
        end
        idle();
        #1;
        tests++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== d[2]) begin
            fails++;
            $display("FAIL b2b_last: rvalid=%b rdata=%h, need 1 a5", r0_rvalid, r0_rdata);
        end
    endtask

    task automatic test_unwritten();
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'd7;
        #1;
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (r1_rvalid !== 1'b1 || r1_rdata !== '0) begin
            fails++;
            $display("FAIL unwritten: rvalid=%b rdata=%h, need 1 0", r1_rvalid, r1_rdata);
        end
    endtask

    task automatic test_reset_midop();
        int n;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'd1;
        #1;
        tests++;
        if (r0_gnt !== 1'b1) begin
            fails++;
            $display("FAIL midrst_gnt: gnt=%b, need 1", r0_gnt);
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        tests++;
        if (r0_rvalid !== 1'b0 || r0_rdata !== '0) begin
            fails++;
            $display("FAIL midrst_rvalid: rvalid=%b rdata=%h, need 0 0", r0_rvalid, r0_rdata);
        end
        @(negedge clk);
        #1;
        tests++;
        if (busy !== 1'b1 || r0_rvalid !== 1'b0 || r0_gnt !== 1'b0) begin
            fails++;
            $display("FAIL midrst_busy: busy=%b rvalid=%b gnt=%b, need 1 0 0", busy, r0_rvalid, r0_gnt);
        end
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_timeout: busy=%b after %0d cycles, need 0", busy, n);
        end
        r0_req = 1'b1; r0_addr = 8'd9;
        #1;
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== '0) begin
            fails++;
            $display("FAIL midrst_recleared: rvalid=%b rdata=%h, need 1 0", r0_rvalid, r0_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << Q); i++) mem[i] = {$urandom, $urandom} | 64'h1;
        rd_q = '0;
        rst = 1'b1;
        idle();
        test_reset();
        test_write_contention();
        test_same_cycle();
        test_alternating();
        test_back_to_back();
        test_unwritten();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
